// File: rtl/tracker_pkg.sv
// Shared types and constants for the packet tracker: stats entries, request flits,
// formatter mux selects and the read-out controller state encoding.
package tracker_pkg;

    localparam int TRACKER_ADDR_W = 10;
    localparam int TRACKER_CNT_W  = TRACKER_ADDR_W + 1;

    typedef struct packed {
        logic [15:0] packet_id;
        logic [31:0] timestamp;
    } tracker_stats_struct;

    localparam int TRACKER_STATS_W = $bits(tracker_stats_struct);

    typedef enum logic [1:0] {
        READ_REQ  = 2'd0,
        META_REQ  = 2'd1,
        READ_RESP = 2'd2,
        META_RESP = 2'd3
    } tracker_req_type;

    typedef struct packed {
        tracker_req_type             req_type;
        logic [TRACKER_ADDR_W-1:0]   start_addr;
        logic [TRACKER_ADDR_W-1:0]   end_addr;
    } tracker_flit;

    localparam int TRACKER_FLIT_W = $bits(tracker_flit);

    typedef enum logic [1:0] {
        FLIT_HDR_1   = 2'd0,
        FLIT_HDR_2   = 2'd1,
        FLIT_TRACKER = 2'd2,
        FLIT_DATA    = 2'd3
    } flit_sel_e;

    typedef enum logic [2:0] {
        IDLE,
        HDR1,
        HDR2,
        TRK,
        RD_ISSUE,
        RD_WAIT,
        DATA
    } tracker_rd_state_e;

    // Inclusive entry count of a circular range; end < start wraps through address 0.
    function automatic logic [TRACKER_CNT_W-1:0] range_count(
        input logic [TRACKER_ADDR_W-1:0] start_addr,
        input logic [TRACKER_ADDR_W-1:0] end_addr
    );
        logic [TRACKER_ADDR_W-1:0] span;
        span = end_addr - start_addr;
        return {1'b0, span} + TRACKER_CNT_W'(1);
    endfunction

endpackage

// File: rtl/tracker_range_walker.sv
// Walks a circular address range: load latches start and entry count, each step
// advances the address (wrapping mod 2^W) and consumes one entry.
module tracker_range_walker
    import tracker_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [TRACKER_ADDR_W-1:0]  start_addr,
    input  logic [TRACKER_ADDR_W-1:0]  end_addr,
    input  logic                       step,
    output logic [TRACKER_ADDR_W-1:0]  cur_addr,
    output logic [TRACKER_CNT_W-1:0]   remaining,
    output logic                       last
);

    logic [TRACKER_ADDR_W-1:0] cur_addr_reg;
    logic [TRACKER_CNT_W-1:0]  remaining_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
        end else if (load) begin
            cur_addr_reg  <= start_addr;
            remaining_reg <= range_count(start_addr, end_addr);
        end else if (step && (remaining_reg != '0)) begin
            cur_addr_reg  <= cur_addr_reg + TRACKER_ADDR_W'(1);
            remaining_reg <= remaining_reg - TRACKER_CNT_W'(1);
        end
    end

    assign cur_addr  = cur_addr_reg;
    assign remaining = remaining_reg;
    assign last      = (remaining_reg == TRACKER_CNT_W'(1));

endmodule

// File: rtl/tracker_read_ctrl.sv
// Host read-out sequencer for the tracker stats RAM: emits HDR_1, HDR_2, TRACKER and
// then one DATA flit per entry, issuing a single RAM read before each DATA flit.
module tracker_read_ctrl
    import tracker_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_val,
    input  logic [TRACKER_FLIT_W-1:0]   req_flit,
    output logic                        req_rdy,
    input  logic [TRACKER_ADDR_W-1:0]   wr_ptr,
    input  logic                        wr_wrapped,
    output logic                        rd_req_val,
    output logic [TRACKER_ADDR_W-1:0]   rd_req_addr,
    input  logic [TRACKER_STATS_W-1:0]  rd_resp_data,
    output logic                        resp_val,
    output logic [1:0]                  resp_sel,
    output logic [TRACKER_FLIT_W-1:0]   resp_tracker,
    output logic [TRACKER_STATS_W-1:0]  resp_entry,
    output logic                        resp_last,
    input  logic                        resp_rdy
);

    tracker_rd_state_e   state_reg;
    tracker_flit         req_reg;
    logic [1:0]          wait_reg;
    logic                req_rdy_reg;
    logic                rd_req_val_reg;
    logic                resp_val_reg;
    logic                resp_last_reg;
    flit_sel_e           resp_sel_reg;
    tracker_flit         resp_tracker_reg;
    tracker_stats_struct entry_reg;

    tracker_flit                req_in;
    tracker_flit                trk_next;
    logic                       req_fire;
    logic                       req_ok;
    logic                       walk_load;
    logic                       walk_step;
    logic [TRACKER_ADDR_W-1:0]  cur_addr;
    logic [TRACKER_CNT_W-1:0]   remaining;
    logic                       walk_last;

    assign req_in    = tracker_flit'(req_flit);
    assign req_fire  = req_val && req_rdy_reg;
    assign req_ok    = (req_in.req_type == READ_REQ) || (req_in.req_type == META_REQ);
    assign walk_load = req_fire && req_ok && (state_reg == IDLE);
    assign walk_step = (state_reg == DATA) && resp_rdy;

    tracker_range_walker u_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (walk_load),
        .start_addr (req_in.start_addr),
        .end_addr   (req_in.end_addr),
        .step       (walk_step),
        .cur_addr   (cur_addr),
        .remaining  (remaining),
        .last       (walk_last)
    );

    // META reports the logger's valid window: whole RAM once wrapped, else 0..wr_ptr-1.
    always_comb begin
        trk_next = req_reg;
        if (req_reg.req_type == META_REQ) begin
            trk_next.req_type   = META_RESP;
            trk_next.start_addr = wr_wrapped ? wr_ptr : '0;
            trk_next.end_addr   = wr_ptr - TRACKER_ADDR_W'(1);
        end else begin
            trk_next.req_type   = READ_RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            req_reg          <= '0;
            wait_reg         <= '0;
            req_rdy_reg      <= 1'b0;
            rd_req_val_reg   <= 1'b0;
            resp_val_reg     <= 1'b0;
            resp_last_reg    <= 1'b0;
            resp_sel_reg     <= FLIT_HDR_1;
            resp_tracker_reg <= '0;
            entry_reg        <= '0;
        end else begin
            rd_req_val_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    req_rdy_reg <= 1'b1;
                    if (req_fire) begin
                        req_reg <= req_in;
                        // Response-type flits arriving as requests are swallowed here.
                        if (req_ok) begin
                            state_reg     <= HDR1;
                            req_rdy_reg   <= 1'b0;
                            resp_val_reg  <= 1'b1;
                            resp_sel_reg  <= FLIT_HDR_1;
                            resp_last_reg <= 1'b0;
                        end
                    end
                end
                HDR1: begin
                    if (resp_rdy) begin
                        state_reg    <= HDR2;
                        resp_sel_reg <= FLIT_HDR_2;
                    end
                end
                HDR2: begin
                    if (resp_rdy) begin
                        state_reg        <= TRK;
                        resp_sel_reg     <= FLIT_TRACKER;
                        resp_tracker_reg <= trk_next;
                        resp_last_reg    <= (req_reg.req_type == META_REQ);
                    end
                end
                TRK: begin
                    if (resp_rdy) begin
                        resp_val_reg  <= 1'b0;
                        resp_last_reg <= 1'b0;
                        if (req_reg.req_type == META_REQ) begin
                            state_reg   <= IDLE;
                            req_rdy_reg <= 1'b1;
                        end else begin
                            state_reg      <= RD_ISSUE;
                            rd_req_val_reg <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    state_reg <= RD_WAIT;
                    wait_reg  <= 2'(RD_LATENCY - 1);
                end
                RD_WAIT: begin
                    if (wait_reg == 2'd0) begin
                        state_reg     <= DATA;
                        entry_reg     <= tracker_stats_struct'(rd_resp_data);
                        resp_val_reg  <= 1'b1;
                        resp_sel_reg  <= FLIT_DATA;
                        resp_last_reg <= (remaining == TRACKER_CNT_W'(1));
                    end else begin
                        wait_reg <= wait_reg - 2'd1;
                    end
                end
                DATA: begin
                    if (resp_rdy) begin
                        resp_val_reg  <= 1'b0;
                        resp_last_reg <= 1'b0;
                        if (walk_last) begin
                            state_reg   <= IDLE;
                            req_rdy_reg <= 1'b1;
                        end else begin
                            state_reg      <= RD_ISSUE;
                            rd_req_val_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_rdy      = req_rdy_reg;
    assign rd_req_val   = rd_req_val_reg;
    assign rd_req_addr  = cur_addr;
    assign resp_val     = resp_val_reg;
    assign resp_sel     = resp_sel_reg;
    assign resp_tracker = resp_tracker_reg;
    assign resp_entry   = entry_reg;
    assign resp_last    = resp_last_reg;

endmodule
